// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package boot_pkg;

    typedef enum logic [2:0] {
        HDR,
        DATA,
        CHK,
        RUN,
        ERR
    } loader_state_t;

    localparam int         LANES    = 4;
    localparam logic [7:0] CHK_SEED = 8'h00;

endpackage

// File: rtl/boot_word_asm.sv
// Little-endian byte-to-word assembler with a one-cycle word_ready pulse.
module boot_word_asm
    import boot_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [1:0]  lane,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [23:0] acc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            lane       <= 2'd0;
            acc        <= 24'd0;
            word       <= 32'd0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= 1'b0;
            if (clr) begin
                lane <= 2'd0;
                acc  <= 24'd0;
            end else if (en) begin
                lane <= lane + 2'd1;
                unique case (lane)
                    2'd0: acc[7:0]   <= din;
                    2'd1: acc[15:8]  <= din;
                    2'd2: acc[23:16] <= din;
                    2'd3: begin
                        // Top byte completes the word; publish it whole.
                        word       <= {din, acc};
                        word_ready <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Streams a COUNT/DATA/CHK frame into instruction memory, then releases the core.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [31:0]   imem_wd,
    output logic          cpu_reset,
    output logic          done,
    output logic          error
);

    loader_state_t state;
    logic [AW:0]   n_words;
    logic [AW-1:0] wptr;
    logic [7:0]    csum;
    logic [1:0]    lane;
    logic          xfer;
    logic          hdr_clr;
    logic          byte_en;
    logic          lane_last;
    logic          last_word;

    assign xfer      = rx_valid & rx_ready;
    assign hdr_clr   = xfer && (state == HDR);
    assign byte_en   = xfer && (state == DATA);
    assign lane_last = (lane == 2'(LANES - 1));
    assign last_word = (({1'b0, wptr} + (AW+1)'(1)) == n_words);

    boot_word_asm u_asm (
        .clk        (clk),
        .reset      (reset),
        .clr        (hdr_clr),
        .en         (byte_en),
        .din        (rx_data),
        .lane       (lane),
        .word       (imem_wd),
        .word_ready (imem_we)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= HDR;
            rx_ready  <= 1'b0;
            imem_addr <= '0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            n_words   <= '0;
            wptr      <= '0;
            csum      <= CHK_SEED;
        end else begin
            unique case (state)
                HDR: begin
                    rx_ready <= 1'b1;
                    if (xfer) begin
                        if (rx_data == 8'd0 || int'(rx_data) > DEPTH) begin
                            state    <= ERR;
                            rx_ready <= 1'b0;
                            error    <= 1'b1;
                        end else begin
                            n_words <= rx_data[AW:0];
                            wptr    <= '0;
                            csum    <= CHK_SEED ^ rx_data;
                            state   <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        csum <= csum ^ rx_data;
                        if (lane_last) begin
                            // Address lines up with the word_ready pulse next cycle.
                            imem_addr <= wptr;
                            wptr      <= wptr + 1'b1;
                            if (last_word) state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        if ((csum ^ rx_data) == CHK_SEED) begin
                            state <= RUN;
                            done  <= 1'b1;
                        end else begin
                            state <= ERR;
                            error <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    rx_ready  <= 1'b0;
                    done      <= 1'b1;
                    cpu_reset <= 1'b0;
                end
                ERR: begin
                    rx_ready  <= 1'b0;
                    error     <= 1'b1;
                    cpu_reset <= 1'b1;
                end
                default: state <= ERR;
            endcase
        end
    end

endmodule
